// File: rtl/dds_multi_lane_phase_gen_if.sv
// Control/data bundle between a DDS channel controller and dds_multi_lane_phase_gen.
// The DUT side uses the slave modport; whoever drives requests and tuning uses master.
interface dds_multi_lane_phase_gen_if #(
  parameter int W     = 43,
  parameter int LANES = 4
);
  // Handshake: dreq_i has no backpressure; each high cycle is one accepted sample.
  // valid_o strobes for one cycle per sample two cycles later. phase_o holds between strobes.
  logic               dreq_i;
  logic               sync_i;
  logic [W-1:0]       tune_i;
  logic               tune_load_i;
  logic [W-1:0]       acc_i;
  logic               acc_load_i;
  logic [W-1:0]       offset_i;
  logic               offset_load_i;
  logic [LANES*W-1:0] phase_o;
  logic               valid_o;
  logic [W-1:0]       acc_o;
  logic               tune_pending_o;

  modport master (
    output dreq_i, sync_i, tune_i, tune_load_i, acc_i, acc_load_i, offset_i, offset_load_i,
    input  phase_o, valid_o, acc_o, tune_pending_o
  );

  modport slave (
    input  dreq_i, sync_i, tune_i, tune_load_i, acc_i, acc_load_i, offset_i, offset_load_i,
    output phase_o, valid_o, acc_o, tune_pending_o
  );
endinterface

// File: rtl/dds_multi_lane_phase_gen.sv
// Multi-lane DDS phase generator: g_lanes phase words per sample, double-buffered tuning.
// Define DDS_PHASE_DITHER_EN to add per-lane LFSR dither to the emitted phases.
module dds_multi_lane_phase_gen #(
  parameter int g_acc_frac_bits = 32,
  parameter int g_lut_size_log2 = 10,
  parameter int g_lanes         = 4,
  parameter int g_sync_tune     = 1,
  parameter int g_dither_bits   = 16
) (
  input logic                      clk_i,
  input logic                      rst_i,
  dds_multi_lane_phase_gen_if.slave bus
);
  localparam int W  = g_acc_frac_bits + g_lut_size_log2 + 1;
  localparam int L2 = $clog2(g_lanes);

  logic [W-1:0]         acc;
  logic [W-1:0]         tune_act;
  logic [W-1:0]         tune_shd;
  logic                 pending;
  logic [W-1:0]         offset;
  logic [W-1:0]         base;
  logic [W-1:0]         step;
  logic                 v1;
  logic [g_lanes*W-1:0] phase_r;
  logic                 valid_r;
  logic                 apply;
  logic [W-1:0]         tune_next;
  logic [g_lanes*W-1:0] lane_vec;

  // A pending shadow is promoted only on a request, and with sync_tune only on a qualified sync.
  assign apply     = pending & bus.dreq_i & (bus.sync_i | (g_sync_tune == 0));
  assign tune_next = apply ? tune_shd : tune_act;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tune_act <= '0;
      tune_shd <= '0;
      pending  <= 1'b0;
    end else begin
      if (apply) begin
        tune_act <= tune_shd;
        pending  <= 1'b0;
      end
      // A load in the same cycle as apply re-arms pending with the fresh value.
      if (bus.tune_load_i) begin
        tune_shd <= bus.tune_i;
        pending  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc    <= '0;
      offset <= '0;
    end else begin
      if (bus.acc_load_i)  acc <= bus.acc_i;
      else if (bus.dreq_i) acc <= acc + tune_next;
      if (bus.offset_load_i) offset <= bus.offset_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1   <= 1'b0;
      base <= '0;
      step <= '0;
    end else begin
      v1 <= bus.dreq_i;
      if (bus.dreq_i) begin
        base <= acc + offset;
        step <= tune_next >> L2;
      end
    end
  end

  // k*step as a sum of shifted copies selected by the constant lane index.
  function automatic logic [W-1:0] scale_step(input logic [W-1:0] s, input int unsigned k);
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < 5; b++) begin
      if (k[b]) r = r + (s << b);
    end
    return r;
  endfunction

`ifdef DDS_PHASE_DITHER_EN
  logic [31:0] lfsr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)   lfsr <= 32'd1;
    else if (v1) lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'hD000_0001 : 32'd0);
  end

  for (genvar k = 0; k < g_lanes; k++) begin : g_lane
    assign lane_vec[k*W +: W] = base + scale_step(step, k)
                              + {{(W-g_dither_bits){1'b0}}, lfsr[k +: g_dither_bits]};
  end
`else
  for (genvar k = 0; k < g_lanes; k++) begin : g_lane
    assign lane_vec[k*W +: W] = base + scale_step(step, k);
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r <= 1'b0;
      phase_r <= '0;
    end else begin
      valid_r <= v1;
      if (v1) phase_r <= lane_vec;
    end
  end

  assign bus.phase_o        = phase_r;
  assign bus.valid_o        = valid_r;
  assign bus.acc_o          = acc;
  assign bus.tune_pending_o = pending;
endmodule
